// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// fetch_unit: owns the PC, drives a synchronous ROM and tags each returned word with its PC.
// Words leave through a credit-limited skid FIFO; redirects squash in-flight words.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter int                ROM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_q,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [1:0]         redirect_kind,
    input  logic [15:0]        branch_imm,
    input  logic [25:0]        jump_index,
    input  logic [31:0]        jr_addr,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic [31:0]        link_addr,
    output logic [1:0]         state_dbg
);

    localparam int DEPTH = ROM_LAT + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]  fetch_pc;
    logic               tag_v  [ROM_LAT];
    logic [ADDR_W-1:0]  tag_pc [ROM_LAT];
    logic [INSTR_W-1:0] fifo_d    [DEPTH];
    logic [INSTR_W-1:0] fifo_d_nx [DEPTH];
    logic [ADDR_W-1:0]  fifo_p    [DEPTH];
    logic [ADDR_W-1:0]  fifo_p_nx [DEPTH];
    logic [2:0]         cnt, cnt_nx;
    logic [2:0]         inflight;
    logic [2:0]         occ;
    logic               accept, pop, push, issue, overflow;
    logic [31:0]        br_sum;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pc_plus1;
    logic               unused_bits;

    assign instr_valid = (cnt != 3'd0);
    assign instr_out   = fifo_d[0];
    assign instr_pc    = fifo_p[0];
    assign rom_addr    = fetch_pc;
    assign state_dbg   = state;
    assign pc_plus1    = instr_pc + 1'b1;
    assign link_addr   = {{(32-ADDR_W){1'b0}}, pc_plus1};

    assign accept = redirect_valid && instr_valid && (redirect_kind != 2'b11);
    assign pop    = instr_valid && (!stall || accept);
    assign push   = tag_v[ROM_LAT-1] && !accept;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + {2'b00, tag_v[i]};
        end
    end

    // Credit: everything issued and not yet retired must fit in the skid FIFO.
    assign occ   = inflight + cnt - {2'b00, pop};
    assign issue = !accept && (occ < 3'(DEPTH));

    assign br_sum = {{(32-ADDR_W){1'b0}}, instr_pc} + 32'd1 + {{16{branch_imm[15]}}, branch_imm};

    always_comb begin
        target = fetch_pc;
        case (redirect_kind)
            2'b00:   target = br_sum[ADDR_W-1:0];
            2'b01:   target = jump_index[ADDR_W-1:0];
            2'b10:   target = jr_addr[ADDR_W-1:0];
            default: target = fetch_pc;
        endcase
    end

    assign unused_bits = ^{br_sum[31:ADDR_W], jump_index[25:ADDR_W], jr_addr[31:ADDR_W]};

    always_comb begin
        fifo_d_nx = fifo_d;
        fifo_p_nx = fifo_p;
        cnt_nx    = cnt;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_d_nx[i] = fifo_d[i+1];
                fifo_p_nx[i] = fifo_p[i+1];
            end
            cnt_nx = cnt - 3'd1;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == cnt_nx) begin
                    fifo_d_nx[i] = rom_q;
                    fifo_p_nx[i] = tag_pc[ROM_LAT-1];
                end
            end
            cnt_nx = cnt_nx + 3'd1;
        end
        if (accept) begin
            cnt_nx = '0;
        end
    end

    assign overflow = push && ((cnt - {2'b00, pop}) == 3'(DEPTH));

    always_comb begin
        state_nx = state;
        case (state)
            BOOT:    state_nx = RUN;
            RUN:     if (accept) state_nx = DRAIN;
            DRAIN:   if (push) state_nx = RUN;
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            cnt      <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_pc[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo_d[i] <= '0;
                fifo_p[i] <= '0;
            end
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            fifo_d <= fifo_d_nx;
            fifo_p <= fifo_p_nx;
            if (accept) begin
                fetch_pc <= target;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 1'b1;
            end
            tag_v[0]  <= issue;
            tag_pc[0] <= fetch_pc;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1] && !accept;
                tag_pc[i] <= tag_pc[i-1];
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !overflow);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// tb_fetch_unit: scoreboard bench; instance a uses ROM_LAT=1, instance b uses ROM_LAT=2.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic a_done = 1'b0;
    logic b_done = 1'b0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ea, eb;

    logic        a_rst, a_stall, a_rv, b_rst, b_stall, b_rv;
    logic [1:0]  a_kind, b_kind, a_state, b_state;
    logic [15:0] a_imm, b_imm;
    logic [25:0] a_jidx, b_jidx;
    logic [31:0] a_jr, b_jr, a_q, b_q, b_q1, a_out, b_out, a_link, b_link;
    logic [7:0]  a_addr, b_addr, a_pc, b_pc;
    logic        a_valid, b_valid;

    function automatic logic [31:0] rom_word(input logic [7:0] a);
        return {a ^ 8'hA5, ~a, 8'h3C, a};
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    always @(posedge clk) a_q <= rom_word(a_addr);
    always @(posedge clk) begin
        b_q1 <= rom_word(b_addr);
        b_q  <= b_q1;
    end

    fetch_unit #(.ADDR_W(8), .INSTR_W(32), .ROM_LAT(1), .RESET_PC(8'h00)) u_a (
        .clk(clk), .reset(a_rst), .rom_addr(a_addr), .rom_q(a_q), .stall(a_stall),
        .redirect_valid(a_rv), .redirect_kind(a_kind), .branch_imm(a_imm),
        .jump_index(a_jidx), .jr_addr(a_jr), .instr_out(a_out), .instr_pc(a_pc),
        .instr_valid(a_valid), .link_addr(a_link), .state_dbg(a_state)
    );

    fetch_unit #(.ADDR_W(8), .INSTR_W(32), .ROM_LAT(2), .RESET_PC(8'h00)) u_b (
        .clk(clk), .reset(b_rst), .rom_addr(b_addr), .rom_q(b_q), .stall(b_stall),
        .redirect_valid(b_rv), .redirect_kind(b_kind), .branch_imm(b_imm),
        .jump_index(b_jidx), .jr_addr(b_jr), .instr_out(b_out), .instr_pc(b_pc),
        .instr_valid(b_valid), .link_addr(b_link), .state_dbg(b_state)
    );

    // Monitors: a word retires when valid and either not stalled or redirected.
    always @(negedge clk) begin
        if (a_rst && a_valid && (!a_stall || (a_rv && a_kind != 2'b11))) begin
            if (qa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_extra_word: got pc 0x%0h, expected none", a_pc);
            end else begin
                ea = qa.pop_front();
                chk("a_pc", 32'(a_pc), 32'(ea));
                chk("a_instr", a_out, rom_word(ea));
                if (ea != 8'hFF) chk("a_link", a_link, 32'(8'(ea + 8'd1)));
            end
        end
    end

    always @(negedge clk) begin
        if (b_rst && b_valid && (!b_stall || (b_rv && b_kind != 2'b11))) begin
            if (qb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_extra_word: got pc 0x%0h, expected none", b_pc);
            end else begin
                eb = qb.pop_front();
                chk("b_pc", 32'(b_pc), 32'(eb));
                chk("b_instr", b_out, rom_word(eb));
                if (eb != 8'hFF) chk("b_link", b_link, 32'(8'(eb + 8'd1)));
            end
        end
    end

    task automatic a_edge();
        @(posedge clk); #1;
    endtask

    task automatic b_edge();
        @(posedge clk); #1;
    endtask

    task automatic a_wait_pc(input logic [7:0] p);
        int k;
        for (k = 0; k < 300; k++) begin
            if (a_valid && a_pc == p) break;
            a_edge();
        end
        chk("a_reach_pc", 32'(a_valid && a_pc == p), 32'd1);
    endtask

    initial begin
        a_rst = 1'b0; a_stall = 1'b0; a_rv = 1'b0; a_kind = 2'b00;
        a_imm = '0; a_jidx = '0; a_jr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("a_rst_addr",  32'(a_addr),  32'h0);
        chk("a_rst_out",   a_out,        32'h0);
        chk("a_rst_pc",    32'(a_pc),    32'h0);
        chk("a_rst_valid", 32'(a_valid), 32'h0);
        chk("a_rst_link",  a_link,       32'h1);
        chk("a_rst_state", 32'(a_state), 32'h0);
        for (int i = 0; i <= 10; i++) qa.push_back(8'(i));
        @(negedge clk); a_rst = 1'b1;
        a_edge();
        chk("a_edge1_valid", 32'(a_valid), 32'h0);
        chk("a_edge1_state", 32'(a_state), 32'h1);
        a_edge();
        chk("a_edge2_valid", 32'(a_valid), 32'h1);
        chk("a_edge2_pc",    32'(a_pc),    32'h0);
        // stall three cycles on pc 5
        a_wait_pc(8'd5);
        a_stall = 1'b1;
        repeat (3) begin
            a_edge();
            chk("a_stall_valid", 32'(a_valid), 32'h1);
            chk("a_stall_pc",    32'(a_pc),    32'h5);
            chk("a_stall_out",   a_out,        rom_word(8'd5));
        end
        a_stall = 1'b0;
        // branch at pc 10, offset -4 -> 7
        a_wait_pc(8'd10);
        a_rv = 1'b1; a_kind = 2'b00; a_imm = 16'hFFFC;
        for (int i = 7; i <= 20; i++) qa.push_back(8'(i));
        a_edge();
        a_rv = 1'b0;
        chk("a_br_bubble1", 32'(a_valid), 32'h0);
        chk("a_br_state",   32'(a_state), 32'h2);
        a_edge();
        chk("a_br_bubble2", 32'(a_valid), 32'h0);
        a_edge();
        chk("a_br_valid",   32'(a_valid), 32'h1);
        chk("a_br_target",  32'(a_pc),    32'h7);
        chk("a_br_state2",  32'(a_state), 32'h1);
        // reserved kind is ignored
        a_wait_pc(8'd15);
        a_rv = 1'b1; a_kind = 2'b11; a_jr = 32'h0000_0003;
        a_edge();
        a_rv = 1'b0;
        chk("a_rsvd_pc", 32'(a_pc), 32'h10);
        // jr 0x1FF -> 0xFF then wrap to 0x00
        a_wait_pc(8'd20);
        a_rv = 1'b1; a_kind = 2'b10; a_jr = 32'h0000_01FF;
        qa.push_back(8'hFF);
        for (int i = 0; i <= 39; i++) qa.push_back(8'(i));
        a_edge();
        a_rv = 1'b0;
        a_edge();
        a_edge();
        chk("a_jr_valid",  32'(a_valid), 32'h1);
        chk("a_jr_target", 32'(a_pc),    32'hFF);
        a_edge();
        chk("a_jr_wrap",   32'(a_pc),    32'h0);
        // asynchronous reset mid-stream at pc 40
        a_wait_pc(8'd40);
        #2 a_rst = 1'b0;
        #1;
        chk("a_mid_valid", 32'(a_valid), 32'h0);
        chk("a_mid_pc",    32'(a_pc),    32'h0);
        chk("a_mid_out",   a_out,        32'h0);
        chk("a_mid_addr",  32'(a_addr),  32'h0);
        chk("a_mid_state", 32'(a_state), 32'h0);
        chk("a_mid_queue", 32'(qa.size()), 32'h0);
        for (int i = 0; i <= 3; i++) qa.push_back(8'(i));
        @(negedge clk); a_rst = 1'b1;
        a_edge();
        a_edge();
        chk("a_restart_valid", 32'(a_valid), 32'h1);
        chk("a_restart_pc",    32'(a_pc),    32'h0);
        for (int k = 0; k < 20 && qa.size() != 0; k++) a_edge();
        a_stall = 1'b1;
        chk("a_final_queue", 32'(qa.size()), 32'h0);
        a_done = 1'b1;
    end

    initial begin
        int k;
        b_rst = 1'b0; b_stall = 1'b0; b_rv = 1'b0; b_kind = 2'b00;
        b_imm = '0; b_jidx = '0; b_jr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("b_rst_valid", 32'(b_valid), 32'h0);
        chk("b_rst_addr",  32'(b_addr),  32'h0);
        for (int i = 0; i <= 12; i++) qb.push_back(8'(i));
        @(negedge clk); b_rst = 1'b1;
        b_edge();
        b_edge();
        chk("b_edge2_valid", 32'(b_valid), 32'h0);
        b_edge();
        chk("b_edge3_valid", 32'(b_valid), 32'h1);
        chk("b_edge3_pc",    32'(b_pc),    32'h0);
        for (k = 0; k < 400; k++) begin
            if (b_valid && b_pc == 8'd12) break;
            b_stall = 1'($urandom_range(0, 1));
            b_edge();
        end
        chk("b_reach_pc", 32'(b_valid && b_pc == 8'd12), 32'd1);
        // jump while stalled -> accepted
        b_stall = 1'b1; b_rv = 1'b1; b_kind = 2'b01; b_jidx = 26'h3FF_FF30;
        for (int i = 8'h30; i <= 8'h40; i++) qb.push_back(8'(i));
        b_edge();
        b_rv = 1'b0; b_stall = 1'b0;
        chk("b_jmp_bubble1", 32'(b_valid), 32'h0);
        b_edge();
        chk("b_jmp_bubble2", 32'(b_valid), 32'h0);
        b_edge();
        chk("b_jmp_bubble3", 32'(b_valid), 32'h0);
        b_edge();
        chk("b_jmp_valid",  32'(b_valid), 32'h1);
        chk("b_jmp_target", 32'(b_pc),    32'h30);
        for (k = 0; k < 400 && qb.size() != 0; k++) begin
            b_stall = 1'($urandom_range(0, 1));
            b_edge();
        end
        b_stall = 1'b1;
        chk("b_final_queue", 32'(qb.size()), 32'h0);
        b_done = 1'b1;
    end

    initial begin
        wait (a_done && b_done);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_cmp++; n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
